// File: rtl/gpc_pkg.sv
// Shared types and helpers for the (1,5;3) GPC expander: vector type, encoder, weighted-sum function.
package gpc_pkg;

   localparam int GPC_MAX = 7;

   typedef logic [5:0] gpc_vec_t;

   // a5 absorbs 2 when it can; the remainder is a thermometer code growing from a0.
   function automatic gpc_vec_t gpc_enc(input logic [2:0] v);
      logic       a5;
      logic [2:0] t;
      logic [4:0] th;
      a5 = (v >= 3'd2);
      t  = a5 ? (v - 3'd2) : v;
      th = 5'b0;
      for (int i = 0; i < 5; i++) begin
         th[i] = (i < int'(t));
      end
      return {a5, th};
   endfunction

   function automatic logic [2:0] gpc_sum(input gpc_vec_t v);
      logic [2:0] s;
      s = {1'b0, v[5], 1'b0};
      for (int i = 0; i < 5; i++) begin
         s = s + {2'b00, v[i]};
      end
      return s;
   endfunction

endpackage

// File: rtl/gpc_1_5_3_expand_if.sv
// Handshake bundle for the expander: count-word input stream and GPC-vector output stream.
interface gpc_1_5_3_expand_if #(
   parameter int CW = 8
);
   import gpc_pkg::*;

   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] in_count;
   logic          out_valid;
   logic          out_ready;
   gpc_vec_t      out_vec;
   logic          out_last;

   modport master (
      output in_valid, in_count, out_ready,
      input  in_ready, out_valid, out_vec, out_last
   );

   modport slave (
      input  in_valid, in_count, out_ready,
      output in_ready, out_valid, out_vec, out_last
   );

endinterface

// File: rtl/gpc_1_5_3_sum.sv
// Combinational (1,5;3) counter built from full adders; reference for the round-trip check.
// Latency 0; no handshake.
module gpc_1_5_3_sum
   import gpc_pkg::*;
(
   input  gpc_vec_t   vec,
   output logic [2:0] sum
);

   logic s1, c1, s0, c2, s2, c3;

   // Weight-1 column: two full adders fold a0..a4 into one sum bit and two carries.
   assign s1 = vec[0] ^ vec[1] ^ vec[2];
   assign c1 = (vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]);
   assign s0 = vec[3] ^ vec[4] ^ s1;
   assign c2 = (vec[3] & vec[4]) | (vec[3] & s1) | (vec[4] & s1);

   assign s2 = c1 ^ c2 ^ vec[5];
   assign c3 = (c1 & c2) | (c1 & vec[5]) | (c2 & vec[5]);

   assign sum = {c3, s2, s0};

endmodule

// File: rtl/gpc_1_5_3_expand.sv
// Splits a count word into (1,5;3) GPC vectors of weight <=7 (GPC_EXPAND_CHECK_EN adds round-trip check).
// Latency: first vector valid the cycle after accept; one vector per cycle while out_ready is high.
// Backpressure: vector/last/rem hold while out_ready is low; new counts accepted only on the last beat.
module gpc_1_5_3_expand
   import gpc_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   gpc_1_5_3_expand_if.slave         bus,
   output logic                      chk_err
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t        state;
   logic [CW-1:0] rem;
   logic          vld_q;
   gpc_vec_t      vec_q;
   logic          last_q;

   logic          fire_out;
   logic          accept;
   logic [2:0]    in_v;
   logic [2:0]    rem_v;

   assign fire_out    = vld_q & bus.out_ready;
   assign bus.in_ready = (state == IDLE) | (fire_out & last_q);
   assign accept      = bus.in_valid & bus.in_ready;

   assign bus.out_valid = vld_q;
   assign bus.out_vec   = vec_q;
   assign bus.out_last  = last_q;

   always_comb begin
      in_v  = (bus.in_count > CW'(GPC_MAX)) ? 3'(GPC_MAX) : bus.in_count[2:0];
      rem_v = (rem > CW'(GPC_MAX)) ? 3'(GPC_MAX) : rem[2:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         rem    <= '0;
         vld_q  <= 1'b0;
         vec_q  <= '0;
         last_q <= 1'b0;
      end else if (accept) begin
         rem    <= bus.in_count - CW'(in_v);
         vec_q  <= gpc_enc(in_v);
         last_q <= (bus.in_count <= CW'(GPC_MAX));
         vld_q  <= 1'b1;
         state  <= EMIT;
      end else if (fire_out && !last_q) begin
         rem    <= rem - CW'(rem_v);
         vec_q  <= gpc_enc(rem_v);
         last_q <= (rem <= CW'(GPC_MAX));
      end else if (fire_out) begin
         vld_q  <= 1'b0;
         state  <= IDLE;
      end
   end

`ifdef GPC_EXPAND_CHECK_EN
   logic [2:0]    beat_sum;
   logic [CW-1:0] acc_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] acc_nxt;
   logic          err_q;

   // Sums the vector as seen on the bus, so a corrupted output is what gets checked.
   gpc_1_5_3_sum u_sum (
      .vec (bus.out_vec),
      .sum (beat_sum)
   );

   assign acc_nxt = acc_q + CW'(beat_sum);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q <= bus.in_count;
         end
         if (fire_out) begin
            if (bus.out_last) begin
               acc_q <= '0;
               if (acc_nxt != cnt_q) begin
                  err_q <= 1'b1;
               end
            end else begin
               acc_q <= acc_nxt;
            end
         end
      end
   end

   assign chk_err = err_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpc_1_5_3_expand.sv
// Directed bench for gpc_1_5_3_expand: fixed count words with hand-derived beat sequences.
module tb_gpc_1_5_3_expand;

   logic clk;
   logic rst_n;
   logic chk_err;
   int   total;
   int   bad;

   gpc_1_5_3_expand_if #(.CW(8)) bus ();

   gpc_1_5_3_expand #(.CW(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus.slave),
      .chk_err (chk_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input logic [5:0] vec, input logic last);
      chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_vec"}, 32'(bus.out_vec), 32'(vec));
      chk({tag, "_last"}, 32'(bus.out_last), 32'(last));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_count  = '0;
      bus.out_ready = 1'b1;
      tick();
      tick();

      chk("rst_vld", 32'(bus.out_valid), 32'd0);
      chk("rst_vec", 32'(bus.out_vec), 32'd0);
      chk("rst_last", 32'(bus.out_last), 32'd0);
      chk("rst_err", 32'(chk_err), 32'd0);
      chk("rst_rdy", 32'(bus.in_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Zero count: single empty vector.
      bus.in_valid = 1'b1;
      bus.in_count = 8'd0;
      tick();
      bus.in_valid = 1'b0;
      chk_beat("z_b1", 6'b000000, 1'b1);
      chk("z_rdy", 32'(bus.in_ready), 32'd1);
      tick();
      chk("z_idle", 32'(bus.out_valid), 32'd0);
      chk("z_rdy2", 32'(bus.in_ready), 32'd1);

      // Count 20: 7 + 7 + 6.
      bus.in_valid = 1'b1;
      bus.in_count = 8'd20;
      tick();
      bus.in_valid = 1'b0;
      chk_beat("c20_b1", 6'b111111, 1'b0);
      chk("c20_rdy", 32'(bus.in_ready), 32'd0);
      tick();
      chk_beat("c20_b2", 6'b111111, 1'b0);
      tick();
      chk_beat("c20_b3", 6'b101111, 1'b1);
      tick();
      chk("c20_idle", 32'(bus.out_valid), 32'd0);

      // Count 9 with three stalled cycles on beat 1.
      bus.in_valid  = 1'b1;
      bus.in_count  = 8'd9;
      bus.out_ready = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_beat("c9_hold", 6'b111111, 1'b0);
         tick();
      end
      chk_beat("c9_hold_end", 6'b111111, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      chk_beat("c9_b2", 6'b100000, 1'b1);
      tick();
      chk("c9_idle", 32'(bus.out_valid), 32'd0);

      // Back-to-back: 7 then 3 with in_valid held.
      bus.in_valid = 1'b1;
      bus.in_count = 8'd7;
      tick();
      bus.in_count = 8'd3;
      chk_beat("bb_b1", 6'b111111, 1'b1);
      chk("bb_rdy", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      chk_beat("bb_b2", 6'b100001, 1'b1);
      tick();
      chk("bb_idle", 32'(bus.out_valid), 32'd0);

      // Count 255 interrupted by reset after ten beats.
      bus.in_valid = 1'b1;
      bus.in_count = 8'd255;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         chk_beat($sformatf("c255_b%0d", i), 6'b111111, 1'b0);
         if (i < 10) tick();
      end
      rst_n = 1'b0;
      tick();
      chk("c255_rst_vld", 32'(bus.out_valid), 32'd0);
      chk("c255_rst_vec", 32'(bus.out_vec), 32'd0);
      chk("c255_rst_last", 32'(bus.out_last), 32'd0);
      rst_n = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_count = 8'd1;
      tick();
      bus.in_valid = 1'b0;
      chk_beat("c1_b1", 6'b000001, 1'b1);
      tick();
      chk("c1_idle", 32'(bus.out_valid), 32'd0);

`ifdef GPC_EXPAND_CHECK_EN
      // Count 14 with a3 knocked out of beat 1: accumulator sees 13.
      bus.in_valid = 1'b1;
      bus.in_count = 8'd14;
      tick();
      bus.in_valid = 1'b0;
      chk_beat("e14_b1", 6'b111111, 1'b0);
      force bus.out_vec = 6'b110111;
      tick();
      release bus.out_vec;
      chk_beat("e14_b2", 6'b111111, 1'b1);
      chk("e14_err_pre", 32'(chk_err), 32'd0);
      tick();
      chk("e14_err", 32'(chk_err), 32'd1);
      tick();
      tick();
      chk("e14_err_sticky", 32'(chk_err), 32'd1);
`else
      chk("no_chk_err", 32'(chk_err), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
